rr_arbiter_timeout: RTL and testbench
=====================================

Name: rr_arbiter_timeout

Overview:
N-way round-robin arbiter for a shared resource, the next generation of the team's 3-requester fixed arbiter.
- A granted requester keeps ownership while its request stays high, up to HOLD_MAX cycles.
- At that limit the grant is forcibly rotated if any other requester is waiting.
- Sits between the request lines of bus masters and the shared resource's select/mux logic.

Parameters:
N, 4, number of requesters (2..16)
HOLD_MAX, 8, maximum consecutive cycles one owner keeps the grant while others wait (>=1)
ID_W, $clog2(N), width of gnt_id

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
req  input  N  request vector; bit i = requester i
gnt  output  N  one-hot grant (all-zero when idle), registered
gnt_id  output  ID_W  index of current owner; 0 when idle, registered
busy  output  1  high while any grant is active, registered
preempt  output  1  one-cycle pulse on the edge where a grant is taken away by timeout, registered

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - gnt=0, gnt_id=0, busy=0, preempt=0.
  - State=IDLE, rotate pointer ptr=0, hold_cnt=0.
- All outputs are registered. req sampled at edge t produces the grant visible after edge t (1-cycle latency).
- Pick function: starting at index s, scan s, s+1, ..., N-1, 0, ... over a masked request vector; return the first set bit (found flag + index).
- State IDLE:
  - If req != 0: grant pick(req, ptr); go to GRANT; hold_cnt=1.
  - Else remain in IDLE; outputs stay zero.
- State GRANT, owner o:
  - Release (req[o]=0 at the edge):
    - ptr <= o+1 mod N.
    - If pick(req & ~(1<<o), o+1) is found, grant that index in the same edge (no idle gap); hold_cnt=1.
    - Else go to IDLE; gnt=0; busy=0.
  - Hold (req[o]=1 and hold_cnt < HOLD_MAX): keep the grant; hold_cnt++.
  - Timeout (req[o]=1 and hold_cnt == HOLD_MAX):
    - If another request is pending: grant pick(req & ~(1<<o), o+1); ptr <= o+1; hold_cnt=1; preempt=1 for exactly one cycle.
    - If no other request is pending: keep o; hold_cnt=1; preempt stays 0.
- preempt is 0 on every edge except a timeout handover.
- gnt is always one-hot or zero. gnt_id and busy are always consistent with gnt.
- hold_cnt width is $clog2(HOLD_MAX+1). It never exceeds HOLD_MAX and never wraps.
- HOLD_MAX=1: under full contention the grant rotates every cycle, with preempt high each cycle.
- Requests arriving while a grant is active are not queued. They are seen only through req at the next arbitration.
- Reset asserted mid-grant: everything clears immediately. After release, arbitration restarts from ptr=0.
- Requests are assumed synchronous to clk. A requester toggling mid-cycle is sampled only at the edge.

Decomposition:
- Shared package/header arb_defs.vh holds:
  - state encodings: ST_IDLE=1'b0, ST_GRANT=1'b1;
  - defaults for N and HOLD_MAX.
- One natural sub-module: rr_pick. It is purely combinational, with inputs (masked req, start index) and outputs (found, index, one-hot).
- rr_pick is instantiated once for both the IDLE and GRANT decisions, using a muxed start index and mask.
- The top level contains only the FSM, ptr, hold_cnt and output registers.

Test Plan:
1. Reset with req=4'b1111 held and rst=0 -> gnt=0000, gnt_id=0, busy=0, preempt=0. After rst=1, the first edge gives gnt=0001, gnt_id=0.
2. req=0100 for 3 cycles, then 0000 -> gnt=0100 one edge after assertion, held 3 cycles, 0000 on the edge after the drop, busy follows gnt. Then req=1111 -> gnt=1000 (ptr=3).
3. req=1111 constant, HOLD_MAX=8 -> sequence 0001, 0010, 0100, 1000, 0001, each held 8 cycles, with a one-cycle preempt pulse at each change.
4. Owner 0 active, req changes 0111 -> 0110 -> gnt becomes 0010 on that same edge, with no zero cycle and preempt=0.
5. req=0001 held for 20 cycles alone -> gnt stays 0001 throughout, preempt never asserts, hold_cnt restarts and never wraps.
6. rst driven low between clock edges during gnt=0100 -> all outputs read 0 before the next rising edge. After release with req=0110 -> gnt=0010.

Source files
------------

// File: rtl/rr_arbiter_timeout_pkg.sv
// Shared definitions for the round-robin arbiter with hold timeout:
// FSM state encoding and default sizing.
package rr_arbiter_timeout_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_HOLD_MAX = 8;

endpackage

// File: rtl/rr_arbiter_timeout_pick.sv
// Circular priority pick: first set bit of req_m at or after start,
// wrapping past N-1 back to 0.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_m,
    input  logic [ID_W-1:0] start,
    output logic            found,
    output logic [ID_W-1:0] idx,
    output logic [N-1:0]    onehot
);

    int              j;
    logic [ID_W-1:0] jj;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        jj     = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            jj = ID_W'(j);
            if (!found && req_m[jj]) begin
                found      = 1'b1;
                idx        = jj;
                onehot[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_timeout.sv
// N-way round-robin arbiter: the owner keeps the grant while requesting,
// but is rotated out after HOLD_MAX cycles if anyone else is waiting.
module rr_arbiter_timeout
    import rr_arbiter_timeout_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int HOLD_MAX = DEF_HOLD_MAX,
    parameter int ID_W     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            preempt,
    output state_t          dbg_state
);

    localparam int              CNT_W   = $clog2(HOLD_MAX + 1);
    localparam logic [ID_W-1:0] LAST    = ID_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [ID_W-1:0]  ptr, ptr_n, own_n, own_inc;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             pre_n;

    logic [N-1:0]     own_bit, pick_mask, pick_onehot;
    logic [ID_W-1:0]  pick_start, pick_idx;
    logic             pick_found;

    logic [N-1:0]     gnt_d;
    logic [ID_W-1:0]  gnt_id_d;
    logic             busy_d;

    // gnt_id doubles as the owner register while in ST_GRANT.
    assign own_bit = N'(1) << gnt_id;
    assign own_inc = (gnt_id == LAST) ? '0 : gnt_id + ID_W'(1);

    // One shared picker: idle scans from ptr, grant scans past the owner.
    assign pick_mask  = (state == ST_IDLE) ? req : (req & ~own_bit);
    assign pick_start = (state == ST_IDLE) ? ptr : own_inc;

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .req_m  (pick_mask),
        .start  (pick_start),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_d;
            gnt_id   <= gnt_id_d;
            busy     <= busy_d;
            preempt  <= pre_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        own_n   = gnt_id;
        pre_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_n = ST_GRANT;
                    own_n   = pick_idx;
                    hold_n  = CNT_ONE;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_id]) begin
                    ptr_n = own_inc;
                    if (pick_found) begin
                        own_n  = pick_idx;
                        hold_n = CNT_ONE;
                    end else begin
                        state_n = ST_IDLE;
                        own_n   = '0;
                        hold_n  = '0;
                    end
                end else if (hold_cnt < CNT_MAX) begin
                    hold_n = hold_cnt + CNT_ONE;
                end else begin
                    // Limit reached: hand over only if someone else waits.
                    hold_n = CNT_ONE;
                    if (pick_found) begin
                        own_n = pick_idx;
                        ptr_n = own_inc;
                        pre_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                own_n   = '0;
                hold_n  = '0;
            end
        endcase
    end

    always_comb begin
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
        if (state_n == ST_GRANT) begin
            gnt_d    = N'(1) << own_n;
            gnt_id_d = own_n;
            busy_d   = 1'b1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rr_arbiter_timeout.sv
// Directed scenarios for rr_arbiter_timeout with a per-cycle expected queue.
module tb_rr_arbiter_timeout;
    import rr_arbiter_timeout_pkg::*;

    localparam int N = 4;
    localparam int W = N + 2 + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;

    logic [N-1:0] gnt, gnt1;
    logic [1:0]   gnt_id, gnt_id1;
    logic         busy, busy1, preempt, preempt1;
    state_t       dbg_state, dbg_state1;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v, obs_v;

    always #5 clk = ~clk;

    rr_arbiter_timeout #(.N(N), .HOLD_MAX(8)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id),
        .busy(busy), .preempt(preempt), .dbg_state(dbg_state)
    );

    rr_arbiter_timeout #(.N(N), .HOLD_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt1), .gnt_id(gnt_id1),
        .busy(busy1), .preempt(preempt1), .dbg_state(dbg_state1)
    );

    function automatic logic [W-1:0] pack(input logic [N-1:0] g, input logic p);
        logic [1:0] id;
        id = '0;
        for (int i = 0; i < N; i++) if (g[i]) id = 2'(i);
        return {g, id, |g, p};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req = 4'b1111;
        rst = 1'b0;
        #1;
        exp_q.push_back(pack(4'b0000, 1'b0));
        exp_v = exp_q.pop_front();
        obs_v = {gnt, gnt_id, busy, preempt};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", obs_v, exp_v);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
        end
        exp_q.push_back(pack(4'b0000, 1'b0));
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        obs_v = {gnt, gnt_id, busy, preempt};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_held_edge got=%b exp=%b", obs_v, exp_v);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(pack(4'b0001, 1'b0));
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        obs_v = {gnt, gnt_id, busy, preempt};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_first_grant got=%b exp=%b", obs_v, exp_v);
        end
        req = '0;
        exp_q.push_back(pack(4'b0000, 1'b0));
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        obs_v = {gnt, gnt_id, busy, preempt};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", obs_v, exp_v);
        end
    endtask

    task automatic test_hold_release();
        logic [N-1:0] stim [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1111, 4'b0000};
        logic [N-1:0] expg [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        for (int k = 0; k < 6; k++) begin
            req = stim[k];
            exp_q.push_back(pack(expg[k], 1'b0));
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            obs_v = {gnt, gnt_id, busy, preempt};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL hold_release[%0d] got=%b exp=%b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] g;
        do_reset();
        for (int k = 0; k < 34; k++) begin
            req = (k < 33) ? 4'b1111 : 4'b0000;
            g   = (k < 33) ? (4'b0001 << ((k / 8) % 4)) : 4'b0000;
            exp_q.push_back(pack(g, (k > 0 && k < 33 && (k % 8) == 0)));
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            obs_v = {gnt, gnt_id, busy, preempt};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL rotation[%0d] got=%b exp=%b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] stim [3] = '{4'b0111, 4'b0110, 4'b0000};
        logic [N-1:0] expg [3] = '{4'b0001, 4'b0010, 4'b0000};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req = stim[k];
            exp_q.push_back(pack(expg[k], 1'b0));
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            obs_v = {gnt, gnt_id, busy, preempt};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%b exp=%b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_lone_hold();
        logic [N-1:0] g;
        do_reset();
        for (int k = 0; k < 26; k++) begin
            if (k < 20)      req = 4'b0001;
            else if (k < 25) req = 4'b0011;
            else             req = 4'b0000;
            g = (k < 24) ? 4'b0001 : ((k == 24) ? 4'b0010 : 4'b0000);
            exp_q.push_back(pack(g, (k == 24)));
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            obs_v = {gnt, gnt_id, busy, preempt};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL lone_hold[%0d] got=%b exp=%b", k, obs_v, exp_v);
            end
            if (k == 10) begin
                checks++;
                if (dbg_state !== ST_GRANT) begin
                    failures++;
                    $display("FAIL lone_hold_state got=%0d exp=%0d", dbg_state, ST_GRANT);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        exp_q.push_back(pack(4'b0100, 1'b0));
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        obs_v = {gnt, gnt_id, busy, preempt};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL async_pre got=%b exp=%b", obs_v, exp_v);
        end
        #3;
        rst = 1'b0;
        exp_q.push_back(pack(4'b0000, 1'b0));
        #1;
        exp_v = exp_q.pop_front();
        obs_v = {gnt, gnt_id, busy, preempt};
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL async_mid_cycle got=%b exp=%b", obs_v, exp_v);
        end
        #2;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req = (k == 0) ? 4'b0110 : 4'b0000;
            exp_q.push_back(pack((k == 0) ? 4'b0010 : 4'b0000, 1'b0));
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            obs_v = {gnt, gnt_id, busy, preempt};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL async_after[%0d] got=%b exp=%b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_hold_one();
        logic [N-1:0] g;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            req = (k < 5) ? 4'b1111 : 4'b0000;
            g   = (k < 5) ? (4'b0001 << (k % 4)) : 4'b0000;
            exp_q.push_back(pack(g, (k > 0 && k < 5)));
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            obs_v = {gnt1, gnt_id1, busy1, preempt1};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL hold_one[%0d] got=%b exp=%b", k, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hold_release();
        test_rotation();
        test_back_to_back();
        test_lone_hold();
        test_async_reset();
        test_hold_one();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drained got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
